// File: rtl/block_alloc_bitmap.sv
// Free-block allocator over a WIDTH x DEPTH bitmap: one allocation offer per cycle,
// REL_PORTS parallel releases, occupancy counters and double-free detection.
module block_alloc_bitmap #(
    parameter  int WIDTH       = 8,
    parameter  int DEPTH       = 128,
    parameter  int REL_PORTS   = 4,
    parameter  int AMFULL_DIFF = 4,
    localparam int AW          = $clog2(WIDTH) + $clog2(DEPTH),
    localparam int TOTAL       = WIDTH * DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    output logic                      alloc_vld,
    output logic [AW-1:0]             alloc_addr,
    input  logic                      alloc_rdy,
    input  logic [REL_PORTS-1:0]      rel_en,
    input  logic [REL_PORTS*AW-1:0]   rel_addr,
    output logic [AW:0]               used_cnt,
    output logic [AW:0]               free_cnt,
    output logic                      full,
    output logic                      almost_full,
    output logic                      empty,
    output logic                      err_dbl_free
);

    localparam logic [AW:0] TOT_C = (AW+1)'(TOTAL);
    localparam logic [AW:0] AMF_C = (AMFULL_DIFF >= TOTAL) ? '0 : (AW+1)'(TOTAL - AMFULL_DIFF);

    logic [TOTAL-1:0]     r_bitmap;
    logic [AW:0]          r_used_cnt;
    logic                 r_alloc_vld;
    logic [AW-1:0]        r_alloc_addr;
    logic                 r_err;

    logic [TOTAL-1:0]     w_nxt_bitmap;
    logic [AW:0]          w_nxt_used;
    logic [AW:0]          w_nrel;
    logic                 w_acc;
    logic                 w_err;
    logic                 w_any_free;
    logic [AW-1:0]        w_free_idx;
    logic [AW-1:0]        w_ra [REL_PORTS];
    logic [REL_PORTS-1:0] w_dup;
    logic [REL_PORTS-1:0] w_rel_ok;

    always_comb begin
        for (int p = 0; p < REL_PORTS; p++) w_ra[p] = rel_addr[p*AW +: AW];
    end

    // A release is legal only on a set bit that is not the one being accepted right now;
    // repeats of the same address on higher ports collapse onto the lowest port.
    always_comb begin
        w_acc        = r_alloc_vld && alloc_rdy;
        w_err        = 1'b0;
        w_dup        = '0;
        w_rel_ok     = '0;
        w_nrel       = '0;
        w_nxt_bitmap = r_bitmap;
        for (int p = 1; p < REL_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (rel_en[q] && (w_ra[q] == w_ra[p])) w_dup[p] = 1'b1;
            end
        end
        for (int p = 0; p < REL_PORTS; p++) begin
            if (rel_en[p]) begin
                if (!r_bitmap[w_ra[p]] || (w_acc && (w_ra[p] == r_alloc_addr))) w_err = 1'b1;
                else if (!w_dup[p]) w_rel_ok[p] = 1'b1;
            end
        end
        for (int p = 0; p < REL_PORTS; p++) begin
            if (w_rel_ok[p]) begin
                w_nxt_bitmap[w_ra[p]] = 1'b0;
                w_nrel                = w_nrel + (AW+1)'(1);
            end
        end
        if (w_acc) w_nxt_bitmap[r_alloc_addr] = 1'b1;
        w_nxt_used = r_used_cnt + {{AW{1'b0}}, w_acc} - w_nrel;
    end

    // Lowest-index free bit of the next-state bitmap.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = TOTAL-1; i >= 0; i--) begin
            if (!w_nxt_bitmap[i]) begin
                w_any_free = 1'b1;
                w_free_idx = AW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitmap     <= '0;
            r_used_cnt   <= '0;
            r_err        <= 1'b0;
            r_alloc_vld  <= 1'b0;
            r_alloc_addr <= '0;
        end else if (flush) begin
            r_bitmap     <= '0;
            r_used_cnt   <= '0;
            r_err        <= 1'b0;
            r_alloc_vld  <= 1'b1;
            r_alloc_addr <= '0;
        end else begin
            r_bitmap    <= w_nxt_bitmap;
            r_used_cnt  <= w_nxt_used;
            r_err       <= w_err;
            r_alloc_vld <= w_any_free;
            if (w_any_free) r_alloc_addr <= w_free_idx;
        end
    end

    assign alloc_vld    = r_alloc_vld;
    assign alloc_addr   = r_alloc_addr;
    assign used_cnt     = r_used_cnt;
    assign free_cnt     = TOT_C - r_used_cnt;
    assign full         = (r_used_cnt == TOT_C);
    assign almost_full  = (r_used_cnt >= AMF_C);
    assign empty        = (r_used_cnt == '0);
    assign err_dbl_free = r_err;

endmodule
